// File: rtl/keypad_scanner_pkg.sv
// Shared types and key map for the 4x3 keypad scanner.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONFIRM,
    S_HELD,
    S_RELEASE
  } state_t;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'd15;

  // rows 0..2 hold digits 1..9 in reading order; row 3 is * 0 #
  function automatic logic [3:0] key_map(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [3:0] code;
    code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    if (row == 2'd3) begin
      unique case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end
    return code;
  endfunction

  function automatic logic [9:0] keypad_of(input logic [3:0] code);
    return (code <= 4'd9) ? (10'd1 << code) : 10'd0;
  endfunction

endpackage

// File: rtl/keypad_row_decode.sv
// Turns one row's synchronized column levels into a key code.
module keypad_row_decode
  import keypad_scanner_pkg::*;
(
  input  logic [1:0] row_idx,
  input  logic [2:0] cols_n,
  output logic [3:0] code,
  output logic       hit,
  output logic       multi
);

  logic [2:0] low;

  always_comb begin
    low   = ~cols_n;
    hit   = |low;
    multi = (low[0] & low[1]) | (low[0] & low[2]) | (low[1] & low[2]);
    code  = KEY_NONE;
    if (low[0])
      code = key_map(row_idx, 2'd0);
    else if (low[1])
      code = key_map(row_idx, 2'd1);
    else if (low[2])
      code = key_map(row_idx, 2'd2);
  end

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning 4x3 keypad reader with full-scan debounce.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_TICKS     = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [9:0] keypad,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_strobe
);

  localparam int TW = $clog2(SCAN_TICKS);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    row_n_q, row_n_d;
  logic          acc_hit_q, acc_hit_d;
  logic          acc_multi_q, acc_multi_d;
  logic [3:0]    acc_code_q, acc_code_d;
  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    keypad_q, keypad_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          strobe_q, strobe_d;

  logic [3:0] row_code, scan_code;
  logic       row_hit, row_multi;
  logic       tick_last, scan_done, scan_hit, scan_multi;
  logic       key_ok, same, cnt_full, do_acc, do_rel;

  keypad_row_decode u_dec (
    .row_idx (row_q),
    .cols_n  (sync2_q),
    .code    (row_code),
    .hit     (row_hit),
    .multi   (row_multi)
  );

  always_comb begin
    sync1_d   = col_n;
    sync2_d   = sync1_q;
    tick_last = tick_q == TW'(SCAN_TICKS - 1);
    tick_d    = tick_last ? '0 : tick_q + TW'(1);
    row_d     = tick_last ? row_q + 2'd1 : row_q;
    row_n_d   = ~(4'b0001 << row_q);

    scan_hit   = acc_hit_q | row_hit;
    scan_multi = acc_multi_q | row_multi | (acc_hit_q & row_hit);
    scan_code  = row_hit ? row_code : acc_code_q;
    scan_done  = tick_last && (row_q == 2'd3);

    acc_hit_d   = acc_hit_q;
    acc_multi_d = acc_multi_q;
    acc_code_d  = acc_code_q;
    if (scan_done) begin
      acc_hit_d   = 1'b0;
      acc_multi_d = 1'b0;
      acc_code_d  = KEY_NONE;
    end else if (tick_last) begin
      acc_hit_d   = scan_hit;
      acc_multi_d = scan_multi;
      acc_code_d  = scan_code;
    end

    key_ok   = scan_done & scan_hit & ~scan_multi;
    same     = key_ok && (scan_code == cand_q);
    cnt_full = (int'(cnt_q) + 1) >= DEBOUNCE_SCANS;

    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    do_acc   = 1'b0;
    do_rel   = 1'b0;
    if (scan_done) begin
      unique case (state_q)
        S_IDLE: if (key_ok) begin
          cand_d = scan_code;
          cnt_d  = CW'(1);
          if (DEBOUNCE_SCANS == 1) do_acc = 1'b1;
          else state_d = S_CONFIRM;
        end
        S_CONFIRM: begin
          if (!key_ok) state_d = S_IDLE;
          else if (!same) begin
            cand_d = scan_code;
            cnt_d  = CW'(1);
          end else if (cnt_full) do_acc = 1'b1;
          else cnt_d = cnt_q + CW'(1);
        end
        S_HELD: if (!same) begin
          cnt_d = CW'(1);
          if (DEBOUNCE_SCANS == 1) do_rel = 1'b1;
          else state_d = S_RELEASE;
        end
        S_RELEASE: begin
          if (same) state_d = S_HELD;
          else if (cnt_full) do_rel = 1'b1;
          else cnt_d = cnt_q + CW'(1);
        end
      endcase
    end

    keypad_d = keypad_q;
    code_d   = code_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    if (do_acc) begin
      state_d  = S_HELD;
      keypad_d = keypad_of(scan_code);
      code_d   = scan_code;
      valid_d  = 1'b1;
      strobe_d = 1'b1;
    end
    if (do_rel) begin
      state_d  = S_IDLE;
      keypad_d = '0;
      code_d   = KEY_NONE;
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      sync1_q     <= 3'b111;
      sync2_q     <= 3'b111;
      tick_q      <= '0;
      row_q       <= 2'd0;
      row_n_q     <= 4'b1110;
      acc_hit_q   <= 1'b0;
      acc_multi_q <= 1'b0;
      acc_code_q  <= KEY_NONE;
      state_q     <= S_IDLE;
      cand_q      <= KEY_NONE;
      cnt_q       <= '0;
      keypad_q    <= '0;
      code_q      <= KEY_NONE;
      valid_q     <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      tick_q      <= tick_d;
      row_q       <= row_d;
      row_n_q     <= row_n_d;
      acc_hit_q   <= acc_hit_d;
      acc_multi_q <= acc_multi_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      keypad_q    <= keypad_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      strobe_q    <= strobe_d;
    end
  end

  assign row_n      = row_n_q;
  assign keypad     = keypad_q;
  assign key_code   = code_q;
  assign key_valid  = valid_q;
  assign key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: matrix model, vector table, random scans.
module tb_keypad_scanner;

  localparam int ST  = 4;
  localparam int DS  = 3;
  localparam int SCN = 4 * ST;

  logic       clock = 1'b0;
  logic       clrn;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [9:0] keypad;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_strobe;

  logic [11:0] keys;
  int checks = 0;
  int errors = 0;
  int n_strobe = 0;
  logic prev_stb = 1'b0;

  typedef struct {
    logic [11:0] k;
    int          code;
    int          stb;
  } vec_t;
  vec_t tbl[$];

  int m_held = 15;
  int m_acc = 0;
  int m_base = 0;
  int m_hist[$];

  always #5 clock = ~clock;

  keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DS)) dut (
    .clock      (clock),
    .clrn       (clrn),
    .col_n      (col_n),
    .row_n      (row_n),
    .keypad     (keypad),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_strobe (key_strobe)
  );

  function automatic int kcode(int r, int c);
    if (r < 3) return r * 3 + c + 1;
    return (c == 0) ? 10 : ((c == 1) ? 0 : 11);
  endfunction

  // a pressed key shorts its column to its row
  function automatic logic [2:0] cols_of(logic [11:0] k, logic [3:0] rn);
    logic [2:0] v;
    v = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!rn[r] && k[kcode(r, c)]) v[c] = 1'b0;
    return v;
  endfunction

  assign col_n = cols_of(keys, row_n);

  function automatic logic [11:0] K(int code);
    logic [11:0] m;
    m = '0;
    m[code] = 1'b1;
    return m;
  endfunction

  function automatic int kp_of(int code);
    int v;
    v = 0;
    if (code < 10) v = 1 << code;
    return v;
  endfunction

  function automatic int scan_res(logic [11:0] k);
    if ($countones(k) != 1) return 15;
    for (int i = 0; i < 12; i++) if (k[i]) return i;
    return 15;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clock) if (key_strobe) n_strobe++;

  always @(negedge clock) begin
    checks++;
    if ($countones(keypad) > 1 || (key_strobe && prev_stb)) begin
      errors++;
      $display("FAIL invariant keypad %b strobe %b prev %b", keypad, key_strobe, prev_stb);
    end
    prev_stb = key_strobe;
  end

  task automatic model_reset();
    m_held = 15;
    m_acc = 0;
    m_hist.delete();
    m_base = n_strobe;
  endtask

  // accept: last DS scans all show one key; release: none of last DS show it
  task automatic model_step(input int res, output int stb);
    bit all_k, none_h;
    stb = 0;
    m_hist.push_back(res);
    if (m_hist.size() >= DS) begin
      all_k = (res != 15);
      none_h = 1'b1;
      for (int i = m_hist.size() - DS; i < m_hist.size(); i++) begin
        if (m_hist[i] != res) all_k = 1'b0;
        if (m_hist[i] == m_held) none_h = 1'b0;
      end
      if (m_held == 15 && all_k) begin
        m_held = res;
        stb = 1;
        m_acc++;
        m_hist.delete();
      end else if (m_held != 15 && none_h) begin
        m_held = 15;
        m_hist.delete();
      end
    end
  endtask

  task automatic scan_check(input logic [11:0] k, input bit use_tbl, input int ecode, input int estb);
    int stb;
    keys = k;
    repeat (SCN) @(posedge clock);
    #1;
    model_step(scan_res(k), stb);
    if (use_tbl) begin
      chk("tbl_code", int'(key_code), ecode);
      chk("tbl_strobe", int'(key_strobe), estb);
      chk("tbl_valid", int'(key_valid), int'(ecode != 15));
      chk("tbl_keypad", int'(keypad), kp_of(ecode));
    end
    chk("mdl_code", int'(key_code), m_held);
    chk("mdl_valid", int'(key_valid), int'(m_held != 15));
    chk("mdl_keypad", int'(keypad), kp_of(m_held));
    chk("mdl_strobe", int'(key_strobe), stb);
    chk("mdl_strobe_total", n_strobe + int'(key_strobe) - m_base, m_acc);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 clrn = 1'b0;
    #1;
    chk("rst_row_n", int'(row_n), 4'b1110);
    chk("rst_keypad", int'(keypad), 0);
    chk("rst_code", int'(key_code), 15);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_strobe", int'(key_strobe), 0);
    @(negedge clock);
    @(negedge clock);
    clrn = 1'b1;
    model_reset();
  endtask

  // kind 0: wait for strobe, kind 1: wait for key_valid low
  task automatic wait_ev(input int kind, input int bound, output int cyc);
    cyc = -1;
    for (int i = 1; i <= bound; i++) begin
      @(posedge clock);
      #1;
      if ((kind == 0 && key_strobe) || (kind == 1 && !key_valid)) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic add(logic [11:0] k, int code, int stb);
    vec_t v;
    v.k = k;
    v.code = code;
    v.stb = stb;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int cyc, n0, hold, sel, a, b;
    logic [11:0] rk;
    logic [3:0] walk [5];
    clrn = 1'b0;
    keys = '0;
    walk[0] = 4'b1110; walk[1] = 4'b1101; walk[2] = 4'b1011;
    walk[3] = 4'b0111; walk[4] = 4'b1110;
    repeat (3) @(negedge clock);
    clrn = 1'b1;
    repeat (7) @(posedge clock);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      repeat ((i == 0) ? 2 : 4) @(posedge clock);
      #1;
      chk("row_walk", int'(row_n), int'(walk[i]));
    end

    add(K(5), 15, 0); add(K(5), 15, 0); add(K(5), 5, 1);
    add(K(5), 5, 0);  add('0, 5, 0);    add('0, 5, 0);
    add('0, 15, 0);
    add(K(1) | K(9), 15, 0); add(K(1) | K(9), 15, 0);
    add(K(1) | K(9), 15, 0);
    add(K(1), 15, 0); add(K(1), 15, 0); add(K(1), 1, 1);
    add('0, 1, 0);    add(K(1), 1, 0);  add('0, 1, 0);
    add('0, 1, 0);    add('0, 15, 0);
    add(K(11), 15, 0); add(K(11), 15, 0); add(K(11), 11, 1);
    add(K(10), 11, 0); add(K(10), 11, 0); add(K(10), 15, 0);
    add(K(10), 15, 0); add(K(10), 15, 0); add(K(10), 10, 1);
    add(K(0), 10, 0);  add(K(0), 10, 0);  add(K(0), 15, 0);
    add(K(0), 15, 0);  add(K(0), 15, 0);  add(K(0), 0, 1);

    do_reset();
    foreach (tbl[i]) scan_check(tbl[i].k, 1'b1, tbl[i].code, tbl[i].stb);

    rk = '0;
    for (int n = 0; n < 120; n += hold) begin
      sel = $urandom_range(0, 9);
      hold = $urandom_range(1, 5);
      if (sel < 2) rk = '0;
      else if (sel < 4) begin
        a = $urandom_range(0, 11);
        b = (a + 1 + $urandom_range(0, 10)) % 12;
        rk = K(a) | K(b);
      end else if (sel < 7 || rk == '0) rk = K($urandom_range(0, 11));
      for (int h = 0; h < hold; h++) scan_check(rk, 1'b0, 0, 0);
    end

    do_reset();
    repeat ($urandom_range(3, 20)) @(posedge clock);
    #1;
    keys = K(5);
    n0 = n_strobe;
    wait_ev(0, 67, cyc);
    chk("p5_latency_ok", int'(cyc > 0), 1);
    chk("p5_keypad", int'(keypad), 10'b0000100000);
    chk("p5_code", int'(key_code), 5);
    chk("p5_valid", int'(key_valid), 1);
    repeat ((cyc > 0) ? 200 - cyc : 200) @(posedge clock);
    #1;
    chk("p5_single_strobe", n_strobe - n0 + int'(key_strobe), 1);
    keys = '0;
    n0 = n_strobe;
    wait_ev(1, 67, cyc);
    chk("r5_latency_ok", int'(cyc > 0), 1);
    chk("r5_code", int'(key_code), 15);
    chk("r5_keypad", int'(keypad), 0);
    repeat (2) @(posedge clock);
    chk("r5_no_strobe", n_strobe - n0, 0);

    n0 = n_strobe;
    for (int i = 0; i < 8; i++) begin
      keys = (i % 2 == 0) ? K(7) : '0;
      repeat (5) @(posedge clock);
    end
    #1;
    chk("b7_quiet", n_strobe - n0 + int'(key_strobe), 0);
    keys = K(7);
    wait_ev(0, 67, cyc);
    chk("b7_latency_ok", int'(cyc > 0), 1);
    chk("b7_code", int'(key_code), 7);
    keys = '0;
    wait_ev(1, 67, cyc);
    chk("b7_release_ok", int'(cyc > 0), 1);

    keys = K(1) | K(9);
    n0 = n_strobe;
    repeat (100) @(posedge clock);
    #1;
    chk("m19_no_strobe", n_strobe - n0 + int'(key_strobe), 0);
    chk("m19_keypad", int'(keypad), 0);
    chk("m19_valid", int'(key_valid), 0);
    keys = K(1);
    wait_ev(0, 67, cyc);
    chk("m1_latency_ok", int'(cyc > 0), 1);
    chk("m1_code", int'(key_code), 1);
    chk("m1_keypad", int'(keypad), 10'b0000000010);
    keys = '0;
    wait_ev(1, 67, cyc);
    chk("m1_release_ok", int'(cyc > 0), 1);

    keys = K(11);
    wait_ev(0, 67, cyc);
    chk("h_latency_ok", int'(cyc > 0), 1);
    chk("h_code", int'(key_code), 11);
    chk("h_keypad", int'(keypad), 0);
    chk("h_valid", int'(key_valid), 1);
    repeat (10) @(posedge clock);
    @(negedge clock);
    #2 clrn = 1'b0;
    #1;
    chk("hrst_code", int'(key_code), 15);
    chk("hrst_valid", int'(key_valid), 0);
    chk("hrst_row_n", int'(row_n), 4'b1110);
    repeat (2) @(negedge clock);
    clrn = 1'b1;
    wait_ev(0, 67, cyc);
    chk("hrst_restrobe_ok", int'(cyc > 0), 1);
    chk("hrst_recode", int'(key_code), 11);
    keys = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives a 4x3 membrane keypad matrix (digits 0-9, '*', '#') row by row and reads the columns.
- Debounces the scan result and presents a held one-hot 10-bit keypad level plus a one-cycle press strobe.
- Sits on the physical side of the keypad interface and feeds the keypad input of the microwave controller's key encoder, so no pushbutton array is needed.

Parameters:
- SCAN_TICKS, 1000: clock cycles each row stays driven. Must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results required to accept a press or a release. Must be >= 1.

Ports:
- clock  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- col_n  in  3  matrix columns, active-low (externally pulled up), asynchronous to clock
- row_n  out  4  matrix row drive, active-low, exactly one row low at a time
- keypad  out  10  one-hot held level, bit d = digit d pressed; matches the encoder keypad input
- key_code  out  4  accepted key code: 0-9 digit, 10 = '*', 11 = '#', 15 = none
- key_valid  out  1  high while an accepted key is held
- key_strobe  out  1  one-clock pulse when a press is accepted

Behaviour:
- Clock and reset: one clock (clock); reset clrn is asynchronous and active-low.
- Reset values:
  - row_n = 4'b1110, keypad = 0, key_code = 4'hF, key_valid = 0, key_strobe = 0.
  - Tick counter = 0, row index = 0, FSM = IDLE.
  - Synchronizer flops reset to 3'b111.
- Synchronizer: col_n passes through a 2-flop synchronizer before any use.
- Key map (row, col0/col1/col2):
  - row0 = 1/2/3, row1 = 4/5/6, row2 = 7/8/9, row3 = */0/#.
- Scanning:
  - The tick counter counts 0..SCAN_TICKS-1.
  - On the last tick, the synchronized columns are sampled for the current row and the row index advances 0->1->2->3->0.
  - row_n is registered from the row index.
  - Sampling on the last tick gives the 2-flop path settled data (SCAN_TICKS >= 4).
- Full-scan result (closed after the row-3 sample):
  - NONE if no column was low in any row.
  - KEY(k) if exactly one key was seen.
  - MULTI if two or more keys were seen. MULTI is treated as NONE.
- Debounce FSM (advances only at full-scan completion; holds otherwise):
  - IDLE: KEY(k) -> CONFIRM, cand = k, cnt = 1.
  - CONFIRM:
    - Result == cand: cnt++.
    - When cnt reaches DEBOUNCE_SCANS -> HELD. keypad/key_code/key_valid update in that cycle; key_strobe pulses that cycle.
    - NONE -> IDLE.
    - Other KEY(j) -> CONFIRM with cand = j, cnt = 1.
    - With DEBOUNCE_SCANS = 1, IDLE goes directly to HELD.
  - HELD:
    - Result == cand: stay.
    - Anything else -> RELEASE, cnt = 1. Outputs are unchanged.
  - RELEASE:
    - Result == cand -> HELD (glitch absorbed), no new strobe.
    - Otherwise cnt++. When cnt reaches DEBOUNCE_SCANS -> IDLE; keypad = 0, key_code = 15, key_valid = 0 in that cycle.
    - A different key appearing during RELEASE is not accepted until the release completes and a fresh CONFIRM runs.
- Output rules:
  - '*' and '#' set key_code and key_valid and pulse key_strobe, but keypad stays 0.
  - keypad is never multi-hot.
  - key_strobe is never high for two consecutive cycles.
- Latency:
  - Press stable from scan start to strobe: DEBOUNCE_SCANS full scans.
  - Worst case: (DEBOUNCE_SCANS+1) x 4 x SCAN_TICKS + 3 clocks.
- clrn asserted mid-scan or mid-press: everything returns to reset values immediately. Scanning restarts at row 0 after clrn deassertion.

Decomposition:
- Shared package (or include) holds:
  - FSM state encoding IDLE/CONFIRM/HELD/RELEASE.
  - Key code constants KEY_STAR = 10, KEY_HASH = 11, KEY_NONE = 15.
  - The row/column-to-code map.
- One sub-module, keypad_row_decode (combinational): row index + synchronized columns -> per-row code / multi flag.

Test Plan (SCAN_TICKS = 4, DEBOUNCE_SCANS = 3; one full scan = 16 clocks; bench models the matrix by shorting col_n[c] to row_n[r] for a pressed key):
- Reset: clrn low mid-scan, col_n = 3'b111 -> row_n = 4'b1110, keypad = 0, key_code = 15, all flags 0; after release row_n walks 1110->1101->1011->0111 every 4 clocks.
- Press '5' (r1, c1) held 200 clocks -> exactly one key_strobe pulse; keypad = 10'b0000100000, key_code = 5, key_valid = 1 within 67 clocks of press; no further strobe while held.
- Release '5' -> keypad = 0, key_code = 15, key_valid = 0 after 3 clean scans (<= 67 clocks); no strobe.
- Bounce: '7' toggles every 5 clocks for 40 clocks then stable -> no strobe during bounce; single strobe, key_code = 7, after the stable phase.
- Hold '1' and '9' simultaneously -> MULTI: no strobe, keypad = 0; release '9' -> strobe with key_code = 1 after 3 scans.
- Press '#' -> key_strobe, key_code = 11, key_valid = 1, keypad = 0. clrn asserted while HELD -> all outputs 0/15 at once; clrn released with key still down -> new strobe after 3 scans.
